// File: rtl/clk_rst_ctrl_if.sv
// Bundle between the clock/reset controller and the logic it serves: PLL lock in,
// system reset, controller state, enable strobes, heartbeat and lock-loss count out.
interface clk_rst_ctrl_if #(
    parameter int N_TICK = 3,
    parameter int LOSS_W = 8
);
    logic              pll_locked;
    logic              sys_rst_n;
    logic [1:0]        state;
    logic [N_TICK-1:0] tick;
    logic              heartbeat;
    logic [LOSS_W-1:0] loss_count;

    modport master (
        input  pll_locked,
        output sys_rst_n, state, tick, heartbeat, loss_count
    );

    modport slave (
        output pll_locked,
        input  sys_rst_n, state, tick, heartbeat, loss_count
    );
endinterface

// File: rtl/clk_rst_ctrl.sv
// PLL lock filter and stretched system-reset sequencer, with lock-loss counting,
// programmable clock-enable strobes and an LED heartbeat.
module clk_rst_ctrl #(
    parameter int                       SYNC_STAGES    = 2,
    parameter int                       LOCK_FILTER    = 16,
    parameter int                       STRETCH_CYCLES = 1024,
    parameter int                       N_TICK         = 3,
    parameter int                       DIV_W          = 24,
    parameter logic [N_TICK*DIV_W-1:0]  TICK_DIV       = {3{24'd1000}},
    parameter int                       LOSS_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clk_rst_ctrl_if.master       bus
);
    localparam int CNT_MAX = (LOCK_FILTER > STRETCH_CYCLES) ? LOCK_FILTER : STRETCH_CYCLES;
    localparam int CNT_W   = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STRETCH   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [LOSS_W-1:0]        loss_q, loss_d;
    logic                     sys_rst_n_q, sys_rst_n_d;
    logic [N_TICK-1:0]        tick_q, tick_d;
    logic                     hb_q, hb_d;
    logic                     lock_s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    assign lock_s = sync_q[SYNC_STAGES-1];

    // The shared counter only advances in the filter and stretch states and
    // restarts from zero on every transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        loss_d  = loss_q;
        case (state_q)
            ST_RESET: state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    if (cnt_q == CNT_W'(LOCK_FILTER - 1)) state_d = ST_STRETCH;
                    else                                  cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_STRETCH: begin
                if (!lock_s)                                    state_d = ST_WAIT_LOCK;
                else if (cnt_q == CNT_W'(STRETCH_CYCLES - 1))   state_d = ST_RUN;
                else                                            cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    if (loss_q != '1) loss_d = loss_q + LOSS_W'(1);
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign sys_rst_n_d = (state_d == ST_RUN);
    assign hb_d        = hb_q ^ tick_d[0];

    // Strokes are registered off next-state, so a RUN exit clears them on the
    // same edge that drops sys_rst_n, even if a wrap was due.
    for (genvar gi = 0; gi < N_TICK; gi++) begin : g_tick
        localparam logic [DIV_W-1:0] DIV = TICK_DIV[gi*DIV_W +: DIV_W];

        if (DIV == '0) begin : g_bad_div
            $error("clk_rst_ctrl: tick divisor must be non-zero");
        end

        logic [DIV_W-1:0] c_q, c_d;

        always_comb begin
            c_d = '0;
            if (state_d == ST_RUN && state_q == ST_RUN && c_q != DIV - DIV_W'(1))
                c_d = c_q + DIV_W'(1);
        end

        assign tick_d[gi] = (state_d == ST_RUN) && (c_d == DIV - DIV_W'(1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) c_q <= '0;
            else        c_q <= c_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            sync_q      <= '0;
            loss_q      <= '0;
            sys_rst_n_q <= 1'b0;
            tick_q      <= '0;
            hb_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            loss_q      <= loss_d;
            sys_rst_n_q <= sys_rst_n_d;
            tick_q      <= tick_d;
            hb_q        <= hb_d;
        end
    end

    assign bus.sys_rst_n  = sys_rst_n_q;
    assign bus.state      = state_q;
    assign bus.tick       = tick_q;
    assign bus.heartbeat  = hb_q;
    assign bus.loss_count = loss_q;
endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Directed bench for clk_rst_ctrl: lock filtering, stretch timing, ticks,
// heartbeat, lock-loss counting/saturation and asynchronous reset.
module tb_clk_rst_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    clk_rst_ctrl_if #(.N_TICK(2), .LOSS_W(2)) bus ();

    clk_rst_ctrl #(
        .SYNC_STAGES    (2),
        .LOCK_FILTER    (4),
        .STRETCH_CYCLES (8),
        .N_TICK         (2),
        .DIV_W          (24),
        .TICK_DIV       ({24'd1, 24'd5}),
        .LOSS_W         (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[%0t] FAIL %s: got %0h expected %0h", $time, tag, obs, exp);
        end else begin
            $display("[%0t] ok   %s: %0h", $time, tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 14 edges from a cleared sync chain with lock held high:
    // 2 sync + 4 filter (STRETCH after edge 6) + 8 stretch (RUN after edge 14).
    task automatic run_seq(input string tag);
        logic [1:0] exp_st;
        for (int k = 1; k <= 14; k++) begin
            step(1);
            exp_st = (k >= 14) ? 2'd3 : ((k >= 6) ? 2'd2 : 2'd1);
            check($sformatf("%s_state_e%0d", tag, k), bus.state, exp_st);
            check($sformatf("%s_sysrst_e%0d", tag, k), bus.sys_rst_n, (k >= 14) ? 1 : 0);
        end
    endtask

    task automatic drop_lock(input string tag, input logic [1:0] exp_loss);
        bus.pll_locked = 1'b0;
        step(2);
        check({tag, "_sysrst_still_hi"}, bus.sys_rst_n, 1);
        step(1);
        check({tag, "_sysrst_lo"}, bus.sys_rst_n, 0);
        check({tag, "_state"}, bus.state, 1);
        check({tag, "_tick"}, bus.tick, 0);
        check({tag, "_loss"}, bus.loss_count, exp_loss);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sysrst"}, bus.sys_rst_n, 0);
        check({tag, "_state"}, bus.state, 0);
        check({tag, "_tick"}, bus.tick, 0);
        check({tag, "_hb"}, bus.heartbeat, 0);
        check({tag, "_loss"}, bus.loss_count, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        bus.pll_locked = 1'b0;

        // Async reset with no clock edge yet
        #3 rst_n = 1'b0;
        #1 check_zero("rst0");
        bus.pll_locked = 1'b1;
        step(2);
        check("rst_hold_state", bus.state, 0);

        // 1: steady lock -> RUN 14 edges after release
        rst_n = 1'b1;
        run_seq("t1");
        check("t1_loss", bus.loss_count, 0);

        // 3: tick[1] every cycle, tick[0] every 5th, heartbeat toggles with tick[0]
        for (int r = 1; r <= 12; r++) begin
            if (r > 1) step(1);
            check($sformatf("t3_tick_r%0d", r), bus.tick, {1'b1, (r % 5) == 0});
            check($sformatf("t3_hb_r%0d", r), bus.heartbeat, (r / 5) % 2);
        end

        // 4: lock loss from RUN
        drop_lock("t4", 2'd1);

        // 2: glitch after 3 high samples restarts the filter
        bus.pll_locked = 1'b1;
        step(3);
        bus.pll_locked = 1'b0;
        step(1);
        bus.pll_locked = 1'b1;
        step(2);
        check("t2_state_e6", bus.state, 1);
        step(3);
        check("t2_state_e9", bus.state, 1);
        step(1);
        check("t2_state_e10", bus.state, 2);
        step(7);
        check("t2_sysrst_e17", bus.sys_rst_n, 0);
        step(1);
        check("t2_sysrst_e18", bus.sys_rst_n, 1);
        check("t2_state_e18", bus.state, 3);
        check("t2_loss", bus.loss_count, 1);
        check("t2_tick_first", bus.tick, 2'b10);

        // 5: repeated losses saturate the 2-bit counter at 3
        for (int i = 2; i <= 5; i++) begin
            drop_lock($sformatf("t5_loss%0d", i), (i > 3) ? 2'd3 : 2'(i));
            bus.pll_locked = 1'b1;
            run_seq($sformatf("t5_relock%0d", i));
        end
        drop_lock("t5_loss6", 2'd3);

        // 6a: async reset during STRETCH
        bus.pll_locked = 1'b1;
        step(8);
        check("t6a_state_pre", bus.state, 2);
        #2 rst_n = 1'b0;
        #1 check_zero("t6a");
        #1 rst_n = 1'b1;
        run_seq("t6a_restart");
        check("t6a_loss_after", bus.loss_count, 0);

        // 6b: async reset during RUN with heartbeat set
        step(4);
        check("t6b_tick_r5", bus.tick, 2'b11);
        check("t6b_hb_r5", bus.heartbeat, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("t6b");
        #1 rst_n = 1'b1;
        run_seq("t6b_restart");
        check("t6b_tick_r1", bus.tick, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
